// File: rtl/itch_pkg.sv
// Shared ITCH definitions: message type codes, per-type byte lengths and the
// decoded field set used by both the parser and the serializer.
package itch_pkg;

    localparam logic [7:0] ITCH_A = 8'h41;
    localparam logic [7:0] ITCH_D = 8'h44;
    localparam logic [7:0] ITCH_E = 8'h45;
    localparam logic [7:0] ITCH_F = 8'h46;
    localparam logic [7:0] ITCH_U = 8'h55;
    localparam logic [7:0] ITCH_X = 8'h58;

    localparam logic [5:0] ITCH_LEN_A = 6'd36;
    localparam logic [5:0] ITCH_LEN_D = 6'd19;
    localparam logic [5:0] ITCH_LEN_E = 6'd31;
    localparam logic [5:0] ITCH_LEN_F = 6'd40;
    localparam logic [5:0] ITCH_LEN_U = 6'd35;
    localparam logic [5:0] ITCH_LEN_X = 6'd23;

    typedef struct packed {
        logic [7:0]  msg_type;
        logic [15:0] stock_locate;
        logic [15:0] tracking_no;
        logic [47:0] timestamp;
        logic [63:0] order_ref_no;
        logic [31:0] shares;
        logic [31:0] price;
        logic [7:0]  buy_sell;
        logic [63:0] stock;
        logic [63:0] match_no;
        logic [63:0] new_order_ref_no;
        logic [31:0] attribution;
    } itch_fields_t;

    // Zero marks an unsupported type.
    function automatic logic [5:0] itch_msg_len(input logic [7:0] t);
        case (t)
            ITCH_A:  return ITCH_LEN_A;
            ITCH_D:  return ITCH_LEN_D;
            ITCH_E:  return ITCH_LEN_E;
            ITCH_F:  return ITCH_LEN_F;
            ITCH_U:  return ITCH_LEN_U;
            ITCH_X:  return ITCH_LEN_X;
            default: return 6'd0;
        endcase
    endfunction

endpackage

// File: rtl/itch_serializer.sv
// Serializes one decoded ITCH order message into a big-endian byte stream
// using the parser framing (start_msg / end_msg / valid / message).
module itch_serializer
    import itch_pkg::*;
#(
    parameter int GAP_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  msg_type,
    input  logic [15:0] stock_locate,
    input  logic [15:0] tracking_no,
    input  logic [47:0] timestamp,
    input  logic [63:0] order_ref_no,
    input  logic [31:0] shares,
    input  logic [31:0] price,
    input  logic [7:0]  buy_sell,
    input  logic [63:0] stock,
    input  logic [63:0] match_no,
    input  logic [63:0] new_order_ref_no,
    input  logic [31:0] attribution,
    output logic [7:0]  message,
    output logic        valid,
    output logic        start_msg,
    output logic        end_msg,
    output logic        bad_type,
    output logic [15:0] tx_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [5:0]   idx_q, idx_d;
    logic [5:0]   len_q, len_d;
    logic [3:0]   gap_q, gap_d;
    itch_fields_t fields_q, fields_d;
    logic [7:0]   message_q, message_d;
    logic         valid_q, valid_d;
    logic         start_q, start_d;
    logic         end_q, end_d;
    logic         bad_q, bad_d;
    logic [15:0]  tx_count_q, tx_count_d;
    itch_fields_t in_fields;
    logic [5:0]   in_len;

    // Bytes 0-18 are common to every type; bytes 19-39 come from a per-type
    // tail packed MSB first. Tail bytes beyond the type length are never reached.
    function automatic logic [7:0] byte_sel(input itch_fields_t f, input logic [5:0] idx);
        logic [151:0] head;
        logic [167:0] tail;
        logic [151:0] head_sh;
        logic [167:0] tail_sh;
        logic [5:0]   k;
        head = {f.msg_type, f.stock_locate, f.tracking_no, f.timestamp, f.order_ref_no};
        case (f.msg_type)
            ITCH_A, ITCH_F: tail = {f.buy_sell, f.shares, f.stock, f.price, f.attribution};
            ITCH_E:         tail = {f.shares, f.match_no, 72'd0};
            ITCH_X:         tail = {f.shares, 136'd0};
            ITCH_U:         tail = {f.new_order_ref_no, f.shares, f.price, 40'd0};
            default:        tail = '0;
        endcase
        head_sh = '0;
        tail_sh = '0;
        if (idx < 6'd19) begin
            k       = 6'd18 - idx;
            head_sh = head >> {k, 3'b000};
            return head_sh[7:0];
        end else begin
            k       = 6'd39 - idx;
            tail_sh = tail >> {k, 3'b000};
            return tail_sh[7:0];
        end
    endfunction

    assign in_fields = '{
        msg_type:         msg_type,
        stock_locate:     stock_locate,
        tracking_no:      tracking_no,
        timestamp:        timestamp,
        order_ref_no:     order_ref_no,
        shares:           shares,
        price:            price,
        buy_sell:         buy_sell,
        stock:            stock,
        match_no:         match_no,
        new_order_ref_no: new_order_ref_no,
        attribution:      attribution
    };
    assign in_len   = itch_msg_len(msg_type);
    assign in_ready = (state_q == S_IDLE);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        len_d      = len_q;
        gap_d      = gap_q;
        fields_d   = fields_q;
        message_d  = 8'h00;
        valid_d    = 1'b0;
        start_d    = 1'b0;
        end_d      = 1'b0;
        bad_d      = 1'b0;
        tx_count_d = tx_count_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    fields_d = in_fields;
                    len_d    = in_len;
                    idx_d    = 6'd0;
                    if (in_len != 6'd0) begin
                        state_d = S_SEND;
                    end else begin
                        bad_d = 1'b1;
                    end
                end
            end
            S_SEND: begin
                message_d = byte_sel(fields_q, idx_q);
                valid_d   = 1'b1;
                start_d   = (idx_q == 6'd0);
                if (idx_q == len_q - 6'd1) begin
                    end_d      = 1'b1;
                    tx_count_d = tx_count_q + 16'd1;
                    idx_d      = 6'd0;
                    if (GAP_CYCLES > 0) begin
                        state_d = S_GAP;
                        gap_d   = 4'(GAP_CYCLES - 1);
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    idx_d = idx_q + 6'd1;
                end
            end
            S_GAP: begin
                if (gap_q == 4'd0) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            idx_q      <= 6'd0;
            len_q      <= 6'd0;
            gap_q      <= 4'd0;
            fields_q   <= '0;
            message_q  <= 8'h00;
            valid_q    <= 1'b0;
            start_q    <= 1'b0;
            end_q      <= 1'b0;
            bad_q      <= 1'b0;
            tx_count_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            len_q      <= len_d;
            gap_q      <= gap_d;
            fields_q   <= fields_d;
            message_q  <= message_d;
            valid_q    <= valid_d;
            start_q    <= start_d;
            end_q      <= end_d;
            bad_q      <= bad_d;
            tx_count_q <= tx_count_d;
        end
    end

    assign message   = message_q;
    assign valid     = valid_q;
    assign start_msg = start_q;
    assign end_msg   = end_q;
    assign bad_type  = bad_q;
    assign tx_count  = tx_count_q;

endmodule

// File: tb/tb_itch_serializer.sv
// Bench for itch_serializer: randomized messages checked cycle by cycle against
// a byte-layout model of the ITCH wire format.
module tb_itch_serializer;

    localparam int GAP = 2;

    typedef struct packed {
        logic [7:0]  t;
        logic [15:0] sl;
        logic [15:0] tn;
        logic [47:0] ts;
        logic [63:0] orn;
        logic [31:0] sh;
        logic [31:0] pr;
        logic [7:0]  bs;
        logic [63:0] st;
        logic [63:0] mn;
        logic [63:0] norn;
        logic [31:0] at;
    } tb_msg_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  msg_type = '0;
    logic [15:0] stock_locate = '0;
    logic [15:0] tracking_no = '0;
    logic [47:0] timestamp = '0;
    logic [63:0] order_ref_no = '0;
    logic [31:0] shares = '0;
    logic [31:0] price = '0;
    logic [7:0]  buy_sell = '0;
    logic [63:0] stock = '0;
    logic [63:0] match_no = '0;
    logic [63:0] new_order_ref_no = '0;
    logic [31:0] attribution = '0;
    logic [7:0]  message;
    logic        valid;
    logic        start_msg;
    logic        end_msg;
    logic        bad_type;
    logic [15:0] tx_count;

    // Expected per-cycle view: {bad_type, in_ready, valid, start_msg, end_msg, message}
    logic [12:0] exp_q[$];
    logic [7:0]  mb_q[$];
    logic [15:0] exp_tx = 16'd0;
    int          n_tests = 0;
    int          n_fail = 0;

    itch_serializer #(.GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .msg_type(msg_type), .stock_locate(stock_locate), .tracking_no(tracking_no),
        .timestamp(timestamp), .order_ref_no(order_ref_no), .shares(shares),
        .price(price), .buy_sell(buy_sell), .stock(stock), .match_no(match_no),
        .new_order_ref_no(new_order_ref_no), .attribution(attribution),
        .message(message), .valid(valid), .start_msg(start_msg), .end_msg(end_msg),
        .bad_type(bad_type), .tx_count(tx_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void push_field(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) mb_q.push_back(v[8*i +: 8]);
    endfunction

    function automatic tb_msg_t rand_msg(input logic [7:0] t);
        tb_msg_t m;
        m.t    = t;
        m.sl   = 16'($urandom);
        m.tn   = 16'($urandom);
        m.ts   = {16'($urandom), $urandom};
        m.orn  = {$urandom, $urandom};
        m.sh   = $urandom;
        m.pr   = $urandom;
        m.bs   = ($urandom_range(0, 1) == 1) ? 8'h42 : 8'h53;
        m.st   = {$urandom, $urandom};
        m.mn   = {$urandom, $urandom};
        m.norn = {$urandom, $urandom};
        m.at   = $urandom;
        return m;
    endfunction

    // Wire layout of a supported message, then the expected cycle sequence:
    // accept cycle, L bytes, GAP idle cycles.
    task automatic model_msg(input tb_msg_t m);
        int len;
        mb_q.delete();
        push_field(64'(m.t), 1);
        push_field(64'(m.sl), 2);
        push_field(64'(m.tn), 2);
        push_field(64'(m.ts), 6);
        push_field(m.orn, 8);
        case (m.t)
            8'h41, 8'h46: begin
                push_field(64'(m.bs), 1);
                push_field(64'(m.sh), 4);
                push_field(m.st, 8);
                push_field(64'(m.pr), 4);
                if (m.t == 8'h46) push_field(64'(m.at), 4);
            end
            8'h45: begin
                push_field(64'(m.sh), 4);
                push_field(m.mn, 8);
            end
            8'h58: push_field(64'(m.sh), 4);
            8'h55: begin
                push_field(m.norn, 8);
                push_field(64'(m.sh), 4);
                push_field(64'(m.pr), 4);
            end
            default: ;
        endcase
        len = mb_q.size();
        exp_q.push_back(13'h0);
        for (int k = 0; k < len; k++)
            exp_q.push_back({1'b0, (k == len - 1) && (GAP == 0), 1'b1,
                             k == 0, k == len - 1, mb_q[k]});
        for (int g = 1; g <= GAP; g++)
            exp_q.push_back({1'b0, g == GAP, 11'h0});
        exp_tx = exp_tx + 16'd1;
    endtask

    task automatic drive_msg(input tb_msg_t m);
        msg_type = m.t; stock_locate = m.sl; tracking_no = m.tn; timestamp = m.ts;
        order_ref_no = m.orn; shares = m.sh; price = m.pr; buy_sell = m.bs;
        stock = m.st; match_no = m.mn; new_order_ref_no = m.norn; attribution = m.at;
    endtask

    task automatic wait_ready(input string name);
        for (int i = 0; i < 200; i++) begin
            if (in_ready === 1'b1) break;
            @(negedge clk);
        end
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s wait_ready: in_ready=%b required 1", name, in_ready);
        end
    endtask

    task automatic send(input tb_msg_t m);
        drive_msg(m);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic check_n(input string name, input int n);
        logic [12:0] e, o;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            o = {bad_type, in_ready, valid, start_msg, end_msg, message};
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL %s cycle %0d: got {bad,rdy,vld,sop,eop,byte}=%b_%b_%b_%b_%b_%h required %b_%b_%b_%b_%b_%h",
                         name, i, o[12], o[11], o[10], o[9], o[8], o[7:0],
                         e[12], e[11], e[10], e[9], e[8], e[7:0]);
            end
        end
    endtask

    task automatic check_tx(input string name);
        n_tests++;
        if (tx_count !== exp_tx) begin
            n_fail++;
            $display("FAIL %s tx_count: got %0d required %0d", name, tx_count, exp_tx);
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({message, valid, start_msg, end_msg, bad_type, tx_count, in_ready} !== {29'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_values: msg=%h v=%b s=%b e=%b bad=%b tx=%0d rdy=%b required 0/0/0/0/0/0/1",
                     message, valid, start_msg, end_msg, bad_type, tx_count, in_ready);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({valid, bad_type, tx_count} !== 18'h0) begin
            n_fail++;
            $display("FAIL reset_idle: v=%b bad=%b tx=%0d required 0/0/0", valid, bad_type, tx_count);
        end
    endtask

    task automatic test_d();
        tb_msg_t m;
        m = rand_msg(8'h44);
        m.sl = 16'h1234;
        m.orn = 64'h0102030405060708;
        wait_ready("d_msg");
        model_msg(m);
        send(m);
        check_n("d_msg", exp_q.size());
        check_tx("d_msg");
    endtask

    task automatic test_a();
        tb_msg_t m;
        m = rand_msg(8'h41);
        m.bs = 8'h42;
        m.sh = 32'd100;
        m.st = 64'h4141504C20202020;
        m.pr = 32'h0016E360;
        wait_ready("a_msg");
        model_msg(m);
        send(m);
        check_n("a_msg", exp_q.size());
        check_tx("a_msg");
    endtask

    task automatic test_bad_type();
        tb_msg_t m;
        m = rand_msg(8'h51);
        wait_ready("bad_type");
        exp_q.push_back({2'b11, 11'h0});
        exp_q.push_back({2'b01, 11'h0});
        send(m);
        check_n("bad_type", exp_q.size());
        check_tx("bad_type");
    endtask

    task automatic test_back_to_back();
        tb_msg_t f, u;
        f = rand_msg(8'h46);
        u = rand_msg(8'h55);
        wait_ready("b2b");
        model_msg(f);
        model_msg(u);
        drive_msg(f);
        in_valid = 1'b1;
        @(posedge clk);
        #1 drive_msg(u);
        fork
            check_n("b2b", exp_q.size());
            begin
                for (int i = 0; i < 100; i++) begin
                    @(negedge clk);
                    if (in_ready === 1'b1) begin
                        @(posedge clk);
                        #1 in_valid = 1'b0;
                        break;
                    end
                end
                in_valid = 1'b0;
            end
        join
        check_tx("b2b");
    endtask

    task automatic test_random();
        logic [7:0] types[6];
        logic [7:0] bad[3];
        tb_msg_t m;
        types = '{8'h41, 8'h44, 8'h45, 8'h46, 8'h55, 8'h58};
        bad   = '{8'h00, 8'h51, 8'hFF};
        for (int n = 0; n < 16; n++) begin
            if ($urandom_range(0, 7) == 0) m = rand_msg(bad[$urandom_range(0, 2)]);
            else                            m = rand_msg(types[$urandom_range(0, 5)]);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            wait_ready("random");
            if (m.t == 8'h00 || m.t == 8'h51 || m.t == 8'hFF) begin
                exp_q.push_back({2'b11, 11'h0});
                exp_q.push_back({2'b01, 11'h0});
            end else begin
                model_msg(m);
            end
            send(m);
            check_n("random", exp_q.size());
        end
        check_tx("random");
    endtask

    task automatic test_reset_mid_msg();
        tb_msg_t m;
        m = rand_msg(8'h45);
        wait_ready("reset_mid");
        model_msg(m);
        send(m);
        check_n("reset_mid", 22);
        exp_q.delete();
        rst_n = 1'b0;
        exp_tx = 16'd0;
        #1;
        n_tests++;
        if ({message, valid, start_msg, end_msg, bad_type, tx_count} !== 28'h0) begin
            n_fail++;
            $display("FAIL reset_mid_async: msg=%h v=%b s=%b e=%b bad=%b tx=%0d required all 0",
                     message, valid, start_msg, end_msg, bad_type, tx_count);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if ({valid, end_msg} !== 2'b00) begin
                n_fail++;
                $display("FAIL reset_mid_hold: v=%b e=%b required 0/0", valid, end_msg);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        m = rand_msg(8'h58);
        wait_ready("after_reset_x");
        model_msg(m);
        send(m);
        check_n("after_reset_x", exp_q.size());
        check_tx("after_reset_x");
    endtask

    initial begin
        test_reset();
        test_d();
        test_a();
        test_bad_type();
        test_back_to_back();
        test_random();
        test_reset_mid_msg();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/itch_serializer.md
# itch_serializer

Transmit-side counterpart of the ITCH message parser. Accepts one fully decoded ITCH order message (type plus field words) over a valid/ready handshake and emits it as a big-endian byte-serial stream. The stream uses the parser's framing: `start_msg`, `end_msg`, `valid`, `message[7:0]`. It sits in the test/replay path, driving the parser input from stored or generated order events.

## Interface
Parameters:
- `GAP_CYCLES`, default 1: idle byte cycles (`valid`=0) inserted after each message's last byte; range 0–15.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: a field set is presented.
- `in_ready` out 1: serializer can accept a field set; high only in IDLE.
- `msg_type` in 8: ASCII type, one of A/D/E/F/U/X (0x41/0x44/0x45/0x46/0x55/0x58).
- `stock_locate` in 16, `tracking_no` in 16, `timestamp` in 48, `order_ref_no` in 64.
- `shares` in 32, `price` in 32, `buy_sell` in 8, `stock` in 64, `match_no` in 64, `new_order_ref_no` in 64, `attribution` in 32.
- `message` out 8: current stream byte.
- `valid` out 1: `message` holds a stream byte.
- `start_msg` out 1: first byte of a message (the type byte).
- `end_msg` out 1: last byte of a message.
- `bad_type` out 1: one-cycle pulse when an accepted `msg_type` is unsupported.
- `tx_count` out 16: number of messages fully emitted; wraps.

## Operation
- Handshake: a transfer occurs when `in_valid && in_ready` on a clock edge. All inputs are captured into a field register on that edge. Inputs are don't-care at all other times.
- Supported type: length L = A 36, D 19, E 31, F 40, U 35, X 23. Enter SEND with `idx`=0.
- Unsupported type: stay in IDLE, pulse `bad_type` the next cycle, emit no bytes, leave `tx_count` unchanged.
- SEND: emit one byte per cycle with `valid`=1. Emission never stalls, because the parser treats `valid`=0 mid-message as an error.
- Byte layout, all fields MSB first:
  - Common: 0 type; 1–2 stock_locate; 3–4 tracking_no; 5–10 timestamp; 11–18 order_ref_no.
  - A: 19 buy_sell; 20–23 shares; 24–31 stock; 32–35 price.
  - F: as A, plus 36–39 attribution.
  - E: 19–22 shares; 23–30 match_no.
  - X: 19–22 shares.
  - U: 19–26 new_order_ref_no; 27–30 shares; 31–34 price.
  - D: no further bytes.
  - Fields not in the type's layout are never emitted.
- Flags: `start_msg`=1 only at `idx`=0; `end_msg`=1 only at `idx`=L−1. On the last byte, increment `tx_count` (mod 2^16).
- After the last byte, go to GAP if `GAP_CYCLES`>0, otherwise IDLE.
- GAP: `valid`, `start_msg`, `end_msg` = 0 for exactly `GAP_CYCLES` cycles, then IDLE.
- States: IDLE → SEND (accept, good type); IDLE → IDLE (accept, bad type); SEND → SEND (`idx`<L−1); SEND → GAP/IDLE (`idx`=L−1); GAP → IDLE (gap counter expires).
- Whenever `valid`=0, `message` = 0x00.

## Timing
- Reset values (asynchronous, immediate): `message` 0x00, `valid` 0, `start_msg` 0, `end_msg` 0, `bad_type` 0, `tx_count` 0, state IDLE, `idx` 0, field register 0.
- `in_ready` = (state==IDLE), combinational. No transfer can occur while `rst_n`=0.
- Accept at edge N → type byte registered at edge N+1. Byte k is valid in the cycle after edge N+1+k. Last byte at edge N+L.
- `in_ready` drops the cycle after acceptance and rises again after the last byte plus `GAP_CYCLES` cycles.
- Minimum spacing between two `start_msg` bytes is L+1+`GAP_CYCLES` cycles, because the IDLE accept cycle carries `valid`=0.
- Reset mid-message: the stream truncates with no `end_msg`. The next message after reset starts cleanly with `start_msg`. `tx_count` does not count a truncated message.
- `bad_type` and a normal send never overlap, because both originate from IDLE.

## Structure
- Shared package `itch_pkg`, also used by the parser:
  - type constants `ITCH_A`, `ITCH_D`, `ITCH_E`, `ITCH_F`, `ITCH_U`, `ITCH_X`;
  - per-type length constants;
  - packed struct `itch_fields_t` for the field register;
  - `itch_msg_len(type)` returning a 6-bit length, 0 for unsupported.
- No sub-module. The byte-select mux (type × `idx`) is a combinational function inside the block, followed by output registers.

## Test plan
- D message: type 0x44, stock_locate 0x1234, order_ref_no 0x0102030405060708 → 19 bytes. Byte0 0x44 with `start_msg`; bytes 1–2 = 12 34; byte 18 = 0x08 with `end_msg`; `tx_count`=1.
- A message: buy_sell 0x42, shares 100, stock "AAPL    ", price 0x0016E360 → 36 bytes. Byte 19 = 0x42; bytes 24–31 = 41 41 50 4C 20 20 20 20; byte 35 = 0x60 with `end_msg`.
- F then U back-to-back with `in_valid` held, `GAP_CYCLES`=2 → 40 bytes; 2 gap cycles plus 1 accept cycle with `valid`=0; then a 35-byte U; `tx_count`=2.
- Unsupported type 0x51 → accepted, `bad_type` pulses exactly 1 cycle, no `valid`, `in_ready` high the following cycle.
- `rst_n` low at byte 20 of an E message → all outputs 0 immediately, no `end_msg`. After release, an X message emits 23 bytes correctly and `tx_count` ends at 1.
- Loopback into the parser for all six types with random fields → `valid_msg` pulses once per message and every parser output equals the injected field.
